button_event_gen: RTL and testbench

Converts the debounced push-button level from the debouncer stage into single-cycle press, release, long-press and auto-repeat events, plus a wrapping press counter. It sits directly downstream of the debouncer and upstream of menu/counter logic that needs clean one-shot events instead of a raw held level.

---
 rtl/button_event_gen_pkg.sv | 31 +++
 rtl/button_event_gen.sv | 140 ++++++++++++++
 tb/tb_button_event_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/button_event_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_event_gen_pkg
// Brief    : Shared constants and state encoding for the push-button event
//            generator.
// Revision : 1.0 - initial release
// ============================================================================
package button_event_gen_pkg;

  // State encoding, kept explicit so downstream debug views stay stable.
  localparam logic [1:0] c_ST_WAIT_REL = 2'd0;
  localparam logic [1:0] c_ST_IDLE     = 2'd1;
  localparam logic [1:0] c_ST_PRESSED  = 2'd2;
  localparam logic [1:0] c_ST_LONG     = 2'd3;

  typedef enum logic [1:0] {
    WAIT_REL = c_ST_WAIT_REL,
    IDLE     = c_ST_IDLE,
    PRESSED  = c_ST_PRESSED,
    LONG     = c_ST_LONG
  } state_t;

  // Default thresholds for a 50 MHz system clock.
  localparam int c_LONG_CYCLES_50M = 50_000_000;  // 1 s hold
  localparam int c_RPT_CYCLES_50M  = 10_000_000;  // 200 ms repeat

  // Width of the wrapping press counter.
  localparam int c_PRESS_CNT_W = 8;

endpackage : button_event_gen_pkg
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : button_event_gen
// Brief    : Turns a debounced button level into one-cycle press, short
//            release, long-press, auto-repeat and long release events, plus a
//            wrapping count of presses. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int LONG_CYCLES = c_LONG_CYCLES_50M,
  parameter int RPT_CYCLES  = c_RPT_CYCLES_50M,
  parameter int CNT_W       = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pb,
  output logic                     press,
  output logic                     short_rel,
  output logic                     long_evt,
  output logic                     rpt,
  output logic                     long_rel,
  output logic                     held,
  output logic [c_PRESS_CNT_W-1:0] press_cnt
);

  // Last timer value before each threshold fires; the timer never goes past
  // these, so it can never wrap.
  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_RPT_LAST  = CNT_W'(RPT_CYCLES - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CNT_W-1:0]           r_tmr;
  logic [CNT_W-1:0]           w_tmr_nxt;
  logic [c_PRESS_CNT_W-1:0]   w_cnt_nxt;
  logic                       w_press;
  logic                       w_short_rel;
  logic                       w_long_evt;
  logic                       w_rpt;
  logic                       w_long_rel;
  logic                       w_held;

  // Next-state, timer, counter and event decode. Release is tested first in
  // PRESSED and LONG so it always wins over a threshold on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_cnt_nxt   = press_cnt;
    w_press     = 1'b0;
    w_short_rel = 1'b0;
    w_long_evt  = 1'b0;
    w_rpt       = 1'b0;
    w_long_rel  = 1'b0;

    case (r_state)
      WAIT_REL: begin
        // A button held through reset must be let go before it can count.
        if (!pb) begin
          w_state_nxt = IDLE;
        end
      end

      IDLE: begin
        if (pb) begin
          w_state_nxt = PRESSED;
          w_press     = 1'b1;
          w_tmr_nxt   = '0;
          w_cnt_nxt   = press_cnt + 1'b1;
        end
      end

      PRESSED: begin
        if (!pb) begin
          w_state_nxt = IDLE;
          w_short_rel = 1'b1;
        end else if (r_tmr == c_LONG_LAST) begin
          w_state_nxt = LONG;
          w_long_evt  = 1'b1;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end

      LONG: begin
        if (!pb) begin
          w_state_nxt = IDLE;
          w_long_rel  = 1'b1;
        end else if (r_tmr == c_RPT_LAST) begin
          w_rpt     = 1'b1;
          w_tmr_nxt = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end

      default: begin
        w_state_nxt = WAIT_REL;
      end
    endcase

    w_held = (w_state_nxt == PRESSED) || (w_state_nxt == LONG);
  end

  // State, shared timer and press counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= WAIT_REL;
      r_tmr     <= '0;
      press_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      press_cnt <= w_cnt_nxt;
    end
  end

  // Registered event pulses and held level; reset cuts any pulse in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press     <= 1'b0;
      short_rel <= 1'b0;
      long_evt  <= 1'b0;
      rpt       <= 1'b0;
      long_rel  <= 1'b0;
      held      <= 1'b0;
    end else begin
      press     <= w_press;
      short_rel <= w_short_rel;
      long_evt  <= w_long_evt;
      rpt       <= w_rpt;
      long_rel  <= w_long_rel;
      held      <= w_held;
    end
  end

endmodule : button_event_gen
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_gen
// Brief    : Self-checking bench for button_event_gen with an event-level
//            reference model, directed scenarios and random button activity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_gen;

  localparam int c_L = 20;
  localparam int c_R = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb  = 1'b0;
  logic       press, short_rel, long_evt, rpt, long_rel, held;
  logic [7:0] press_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: whether the button has been seen released since reset,
  // whether a press is in progress and how many edges it has lasted.
  bit         m_armed, m_down;
  int         m_hold;
  logic [7:0] m_cnt;
  bit         m_press, m_short, m_long, m_rpt, m_lrel, m_held;

  // Pulse tallies taken from the DUT outputs, for literal expectations.
  int n_press, n_short, n_long, n_rpt, n_lrel;
  int c_press, c_long, c_rpt1;

  button_event_gen #(
    .LONG_CYCLES(c_L),
    .RPT_CYCLES (c_R),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pb       (pb),
    .press    (press),
    .short_rel(short_rel),
    .long_evt (long_evt),
    .rpt      (rpt),
    .long_rel (long_rel),
    .held     (held),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, expressed in terms of press duration in edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_armed = 0; m_down = 0; m_hold = 0; m_cnt = 8'd0;
      m_press = 0; m_short = 0; m_long = 0; m_rpt = 0; m_lrel = 0; m_held = 0;
    end else begin
      m_press = 0; m_short = 0; m_long = 0; m_rpt = 0; m_lrel = 0;
      if (!m_down) begin
        if (!pb) m_armed = 1;
        else if (m_armed) begin
          m_down  = 1;
          m_hold  = 0;
          m_press = 1;
          m_cnt   = m_cnt + 8'd1;
        end
      end else if (!pb) begin
        m_down = 0;
        if (m_hold < c_L) m_short = 1;
        else              m_lrel  = 1;
      end else begin
        m_hold = m_hold + 1;
        if (m_hold == c_L) m_long = 1;
        else if (m_hold > c_L && ((m_hold - c_L) % c_R) == 0) m_rpt = 1;
      end
      m_held = m_down;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, plus pulse tallies.
  always @(negedge clk) begin
    check("outputs_vs_model",
          int'({press, short_rel, long_evt, rpt, long_rel, held, press_cnt}),
          int'({m_press, m_short, m_long, m_rpt, m_lrel, m_held, m_cnt}));
    if (press)     begin n_press++; c_press = cyc; end
    if (short_rel) n_short++;
    if (long_evt)  begin n_long++; c_long = cyc; end
    if (rpt)       begin if (n_rpt == 0) c_rpt1 = cyc; n_rpt++; end
    if (long_rel)  n_lrel++;
  end

  task automatic clear_tally();
    n_press = 0; n_short = 0; n_long = 0; n_rpt = 0; n_lrel = 0;
    c_press = -1; c_long = -1; c_rpt1 = -1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    clear_tally();
    // Reset state
    cycles(2);
    check("reset_held", int'(held), 0);
    check("reset_cnt", int'(press_cnt), 0);
    check("reset_pulses", int'({press, short_rel, long_evt, rpt, long_rel}), 0);
    rst = 1'b0;

    // Short press: 10 cycles high
    pb = 0; cycles(3); clear_tally();
    pb = 1; cycles(10);
    pb = 0; cycles(4);
    check("short_press_cnt", n_press, 1);
    check("short_rel_cnt", n_short, 1);
    check("short_no_long", n_long, 0);
    check("short_press_count_val", int'(press_cnt), 1);

    // Long press with repeats: 40 cycles high
    clear_tally();
    pb = 1; cycles(40);
    pb = 0; cycles(4);
    check("long_press_cnt", n_press, 1);
    check("long_evt_cnt", n_long, 1);
    check("long_evt_delay", c_long - c_press, 20);
    check("rpt_cnt", n_rpt, 3);
    check("rpt_first_delay", c_rpt1 - c_long, 5);
    check("long_rel_cnt", n_lrel, 1);
    check("long_no_short", n_short, 0);

    // Release exactly on the threshold edge
    clear_tally();
    pb = 1; cycles(20);
    pb = 0; cycles(4);
    check("thr_short_rel", n_short, 1);
    check("thr_no_long", n_long, 0);
    check("thr_no_long_rel", n_lrel, 0);

    // Held through reset
    pb = 1; do_reset(); clear_tally();
    cycles(30);
    check("hold_rst_no_press", n_press, 0);
    check("hold_rst_held", int'(held), 0);
    pb = 0; cycles(1);
    pb = 1; cycles(1);
    check("hold_rst_press_now", int'(press), 1);
    cycles(1);
    check("hold_rst_press_one", n_press, 1);
    pb = 0; cycles(3);

    // Counter wrap: 256 short presses
    do_reset(); cycles(2); clear_tally();
    repeat (256) begin
      pb = 1; cycles(3);
      pb = 0; cycles(2);
    end
    cycles(2);
    check("wrap_press_pulses", n_press, 256);
    check("wrap_cnt_zero", int'(press_cnt), 0);

    // Async reset while in LONG
    clear_tally();
    pb = 1; cycles(25);
    check("pre_rst_long", n_long, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs",
          int'({press, short_rel, long_evt, rpt, long_rel, held, press_cnt}), 0);
    cycles(2);
    pb = 0; rst = 1'b0; cycles(4);
    check("async_rst_no_long_rel", n_lrel, 0);

    // Random button activity with occasional resets
    for (int s = 0; s < 300; s++) begin
      pb = ~pb;
      cycles($urandom_range(1, 32));
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        cycles(1);
        rst = 1'b0;
      end
    end
    pb = 0; cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_button_event_gen
`default_nettype wire
